// File: rtl/fp_pkg.sv
// Shared single-precision float format for the FP adder pipeline.
package fp;

  localparam int FRACTION_BITS = 23;
  localparam int EXP_BITS      = 8;

  localparam logic [EXP_BITS-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic                     sign;
    logic [EXP_BITS-1:0]      exp;
    logic [FRACTION_BITS-1:0] frac;
  } float;

endpackage

// File: rtl/fp_carry_round.sv
// Carry-out path of the normalizer: shift right by one, round to nearest
// even on the dropped bit, and bump the exponent (saturating to Inf).
module fp_carry_round
  import fp::*;
(
  input  logic [FRACTION_BITS+1:0] mant,
  input  logic [EXP_BITS-1:0]      exp,
  output logic [FRACTION_BITS-1:0] frac,
  output logic [EXP_BITS-1:0]      exp_next,
  output logic                     overflow
);

  localparam int F  = FRACTION_BITS;
  localparam int EW = EXP_BITS + 1;

  logic [F-1:0]  frac_kept;
  logic          round_up;
  logic [F:0]    frac_sum;
  logic          sig_ovf;
  logic [EW-1:0] exp_wide;

  // Round the fraction field only; a carry out of it with the carry bit set
  // means the significand rounded up to 2.0 and needs one more exponent step.
  always_comb begin
    frac_kept = mant[F:1];
    round_up  = mant[0] & mant[1];
    frac_sum  = {1'b0, frac_kept} + {{F{1'b0}}, round_up};
    sig_ovf   = frac_sum[F] & mant[F+1];
    exp_wide  = {1'b0, exp} + EW'(1) + EW'(sig_ovf);
    overflow  = exp_wide >= {1'b0, EXP_MAX};
    exp_next  = overflow ? EXP_MAX : exp_wide[EW-2:0];
    frac      = (overflow || sig_ovf) ? '0 : frac_sum[F-1:0];
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalizer: carry-out handled with an RNE right shift, otherwise
// left-shifts one bit per cycle until normalized or denormal.
module fp_normalize_round
  import fp::*;
#(
  parameter bit FTZ = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FRACTION_BITS+1:0] sum,
  input  logic [EXP_BITS-1:0]      exp_in,
  input  logic                     sign_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output float                     result,
  output logic                     busy
);

  localparam int F  = FRACTION_BITS;
  localparam int EW = EXP_BITS + 1;

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [F+1:0]        mant_q, mant_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;
  logic                sign_q, sign_d;
  float                result_q, result_d;

  logic [F+1:0]        mant_shl;
  logic [EW-1:0]       exp_dec;
  logic [F-1:0]        cr_frac;
  logic [EXP_BITS-1:0] cr_exp;
  logic                cr_ovf;

  assign mant_shl = {mant_q[F:0], 1'b0};
  assign exp_dec  = {1'b0, exp_q} - EW'(1);

  fp_carry_round u_carry_round (
    .mant     (mant_q),
    .exp      (exp_q),
    .frac     (cr_frac),
    .exp_next (cr_exp),
    .overflow (cr_ovf)
  );

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update; the result is latched on entry to DONE.
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d  = sum;
          exp_d   = exp_in;
          sign_d  = sign_in;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = DONE;
        if (exp_q == EXP_MAX) begin
          result_d.sign = sign_q;
          result_d.exp  = exp_q;
          result_d.frac = mant_q[F-1:0];
        end else if (mant_q == '0) begin
          result_d = '0;
        end else if (mant_q[F+1]) begin
          result_d.sign = sign_q;
          result_d.exp  = cr_exp;
          result_d.frac = cr_ovf ? '0 : cr_frac;
        end else if (mant_q[F]) begin
          result_d.sign = sign_q;
          result_d.exp  = exp_q;
          result_d.frac = mant_q[F-1:0];
        end else if (exp_q <= EXP_BITS'(1)) begin
          result_d.sign = sign_q;
          result_d.exp  = '0;
          result_d.frac = FTZ ? '0 : mant_q[F-1:0];
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mant_d = mant_shl;
        exp_d  = exp_dec[EXP_BITS-1:0];
        if (mant_shl[F]) begin
          result_d.sign = sign_q;
          result_d.exp  = exp_dec[EXP_BITS-1:0];
          result_d.frac = mant_shl[F-1:0];
          state_d       = DONE;
        end else if (exp_dec == EW'(1)) begin
          // Reached the minimum exponent still unnormalized: encode as denormal.
          result_d.sign = sign_q;
          result_d.exp  = '0;
          result_d.frac = FTZ ? '0 : mant_shl[F-1:0];
          state_d       = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    result    = result_q;
  end

endmodule
